// File: rtl/cgra_lm_bank_xbar_pkg.sv
// cgra_lm_pkg: shared sizing helpers and default widths for the LM bank crossbar
package cgra_lm_pkg;
  localparam int LM_DEF_D_WIDTH = 32;
  localparam int LM_DEF_NUM_BANKS = 4;
  localparam int LM_BYTE_WIDTH = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  localparam int LM_DEF_BANK_SEL_WIDTH = clog2(LM_DEF_NUM_BANKS);
  localparam int LM_DEF_NUM_ENABLES = LM_DEF_D_WIDTH / LM_BYTE_WIDTH;
endpackage

// File: rtl/cgra_lm_bank_arbiter.sv
// cgra_lm_bank_arbiter: one-hot grant for one bank; round-robin when LM_XBAR_RR_ARB_EN is defined, else fixed priority
module cgra_lm_bank_arbiter import cgra_lm_pkg::*; #(
  parameter int NUM_PORTS = 4
) (
  input  logic                 iClk,
  input  logic                 iReset,
  input  logic [NUM_PORTS-1:0] iReq,
  output logic [NUM_PORTS-1:0] oGrant
);
`ifdef LM_XBAR_RR_ARB_EN
  localparam int PW = clog2(NUM_PORTS);
  logic [PW-1:0] ptr, ptrNext;
  // Scan from farthest to nearest offset so the port closest to ptr wins last.
  always_comb begin
    oGrant = '0;
    ptrNext = ptr;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (iReq[(int'(ptr) + i) % NUM_PORTS]) begin
        oGrant = '0;
        oGrant[(int'(ptr) + i) % NUM_PORTS] = 1'b1;
        ptrNext = PW'((int'(ptr) + i + 1) % NUM_PORTS);
      end
  end
  always_ff @(posedge iClk or negedge iReset)
    if (!iReset) ptr <= '0;
    else ptr <= ptrNext;
`else
  logic unusedClkReset;
  assign unusedClkReset = iClk ^ iReset;
  always_comb begin
    oGrant = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (iReq[i]) begin
        oGrant = '0;
        oGrant[i] = 1'b1;
      end
  end
`endif
endmodule

// File: rtl/cgra_lm_bank_xbar.sv
// cgra_lm_bank_xbar: word-interleaved crossbar from NUM_PORTS LM requesters to NUM_BANKS single-port banks
// LM_XBAR_RR_ARB_EN selects round-robin bank arbitration; undefined gives fixed lowest-index priority.
module cgra_lm_bank_xbar import cgra_lm_pkg::*; #(
  parameter  int D_WIDTH = 32,
  parameter  int NUM_PORTS = 4,
  parameter  int NUM_BANKS = 4,
  parameter  int LM_ADDR_WIDTH = 16,
  parameter  int LM_MEM_ADDR_WIDTH = 8,
  localparam int LM_NUM_ENABLES = D_WIDTH / 8
) (
  input  logic                                   iClk,
  input  logic                                   iReset,
  input  logic [NUM_PORTS-1:0]                   iReq_Valid,
  input  logic [NUM_PORTS-1:0]                   iReq_Write,
  input  logic [NUM_PORTS*LM_ADDR_WIDTH-1:0]     iReq_Address,
  input  logic [NUM_PORTS*D_WIDTH-1:0]           iReq_WriteData,
  input  logic [NUM_PORTS*LM_NUM_ENABLES-1:0]    iReq_ByteEnable,
  output logic [NUM_PORTS-1:0]                   oReq_Stall,
  output logic [NUM_PORTS-1:0]                   oResp_Valid,
  output logic [NUM_PORTS*D_WIDTH-1:0]           oResp_ReadData,
  output logic [NUM_BANKS*LM_NUM_ENABLES-1:0]    oBank_WriteEnable,
  output logic [NUM_BANKS-1:0]                   oBank_ReadEnable,
  output logic [NUM_BANKS*LM_MEM_ADDR_WIDTH-1:0] oBank_Address,
  output logic [NUM_BANKS*D_WIDTH-1:0]           oBank_WriteData,
  input  logic [NUM_BANKS*D_WIDTH-1:0]           iBank_ReadData
);
  localparam int BANK_SEL_WIDTH = clog2(NUM_BANKS);
  localparam int PW = clog2(NUM_PORTS);
  logic [NUM_PORTS-1:0] reqToBank [NUM_BANKS];
  logic [NUM_PORTS-1:0] grant [NUM_BANKS];
  logic [NUM_PORTS-1:0] portGrant;
  logic [LM_MEM_ADDR_WIDTH-1:0] localAddr [NUM_PORTS];
  logic [NUM_BANKS-1:0] rdPending;
  logic [PW-1:0] rdPort [NUM_BANKS];
  logic [PW-1:0] rdPortNext [NUM_BANKS];
  // Requests are masked during reset so banks see no enables.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) reqToBank[b] = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      localAddr[p] = iReq_Address[p*LM_ADDR_WIDTH+BANK_SEL_WIDTH +: LM_MEM_ADDR_WIDTH];
      for (int b = 0; b < NUM_BANKS; b++)
        reqToBank[b][p] = iReset & iReq_Valid[p]
          & ((int'(iReq_Address[p*LM_ADDR_WIDTH +: LM_ADDR_WIDTH]) & (NUM_BANKS - 1)) == b);
    end
  end
  for (genvar b = 0; b < NUM_BANKS; b++) begin : gBank
    cgra_lm_bank_arbiter #(.NUM_PORTS(NUM_PORTS)) uArb (
      .iClk(iClk),
      .iReset(iReset),
      .iReq(reqToBank[b]),
      .oGrant(grant[b])
    );
  end
  always_comb begin
    portGrant = '0;
    for (int b = 0; b < NUM_BANKS; b++) portGrant = portGrant | grant[b];
  end
  assign oReq_Stall = iReq_Valid & ~portGrant;
  always_comb begin
    oBank_WriteEnable = '0;
    oBank_ReadEnable = '0;
    oBank_Address = '0;
    oBank_WriteData = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rdPortNext[b] = '0;
      for (int p = 0; p < NUM_PORTS; p++)
        if (grant[b][p]) begin
          oBank_WriteEnable[b*LM_NUM_ENABLES +: LM_NUM_ENABLES] =
            iReq_Write[p] ? iReq_ByteEnable[p*LM_NUM_ENABLES +: LM_NUM_ENABLES] : '0;
          oBank_ReadEnable[b] = ~iReq_Write[p];
          oBank_Address[b*LM_MEM_ADDR_WIDTH +: LM_MEM_ADDR_WIDTH] = localAddr[p];
          oBank_WriteData[b*D_WIDTH +: D_WIDTH] = iReq_Write[p] ? iReq_WriteData[p*D_WIDTH +: D_WIDTH] : '0;
          rdPortNext[b] = PW'(p);
        end
    end
  end
  always_ff @(posedge iClk or negedge iReset)
    if (!iReset) begin
      rdPending <= '0;
      for (int b = 0; b < NUM_BANKS; b++) rdPort[b] <= '0;
    end else begin
      rdPending <= oBank_ReadEnable;
      for (int b = 0; b < NUM_BANKS; b++) rdPort[b] <= rdPortNext[b];
    end
  // A port holds at most one grant per cycle, so at most one bank matches here.
  always_comb begin
    oResp_Valid = '0;
    oResp_ReadData = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      for (int b = 0; b < NUM_BANKS; b++)
        if (rdPending[b] && rdPort[b] == PW'(p)) begin
          oResp_Valid[p] = 1'b1;
          oResp_ReadData[p*D_WIDTH +: D_WIDTH] = iBank_ReadData[b*D_WIDTH +: D_WIDTH];
        end
  end
endmodule

// File: tb/tb_cgra_lm_bank_xbar.sv
// tb_cgra_lm_bank_xbar: directed and random traffic against a rule-level model of the LM bank crossbar
module tb_cgra_lm_bank_xbar;
  localparam int DW = 32, NP = 4, NB = 4, AW = 16, MAW = 8, NE = DW / 8;
  logic iClk = 1'b0, iReset = 1'b0;
  logic [NP-1:0] iReq_Valid, iReq_Write, oReq_Stall, oResp_Valid;
  logic [NP*AW-1:0] iReq_Address;
  logic [NP*DW-1:0] iReq_WriteData, oResp_ReadData;
  logic [NP*NE-1:0] iReq_ByteEnable;
  logic [NB*NE-1:0] oBank_WriteEnable;
  logic [NB-1:0] oBank_ReadEnable;
  logic [NB*MAW-1:0] oBank_Address;
  logic [NB*DW-1:0] oBank_WriteData, bankRd;
  always #5 iClk = ~iClk;
  cgra_lm_bank_xbar #(.D_WIDTH(DW), .NUM_PORTS(NP), .NUM_BANKS(NB), .LM_ADDR_WIDTH(AW), .LM_MEM_ADDR_WIDTH(MAW)) dut (
    .iClk(iClk), .iReset(iReset),
    .iReq_Valid(iReq_Valid), .iReq_Write(iReq_Write), .iReq_Address(iReq_Address),
    .iReq_WriteData(iReq_WriteData), .iReq_ByteEnable(iReq_ByteEnable),
    .oReq_Stall(oReq_Stall), .oResp_Valid(oResp_Valid), .oResp_ReadData(oResp_ReadData),
    .oBank_WriteEnable(oBank_WriteEnable), .oBank_ReadEnable(oBank_ReadEnable),
    .oBank_Address(oBank_Address), .oBank_WriteData(oBank_WriteData), .iBank_ReadData(bankRd)
  );
  function automatic logic [DW-1:0] initWord(int i);
    logic [DW-1:0] x;
    x = DW'(i);
    return (x * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction
  // Bank memories: word index is {local address, bank}; reloaded while reset is held.
  logic [DW-1:0] envMem [1024];
  always @(posedge iClk)
    if (!iReset) begin
      for (int i = 0; i < 1024; i++) envMem[i] <= initWord(i);
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (oBank_ReadEnable[b]) bankRd[b*DW +: DW] <= envMem[{oBank_Address[b*MAW +: MAW], 2'(b)}];
        for (int e = 0; e < NE; e++)
          if (oBank_WriteEnable[b*NE+e]) envMem[{oBank_Address[b*MAW +: MAW], 2'(b)}][e*8 +: 8] <= oBank_WriteData[b*DW+e*8 +: 8];
      end
    end
  logic [DW-1:0] refMem [1024];
  logic rv [NP], rw [NP];
  logic [AW-1:0] ra [NP];
  logic [DW-1:0] rd [NP];
  logic [NE-1:0] rbe [NP];
  int ptr [NB];
  logic [NP-1:0] expRespV, lastGrant;
  logic [NP*DW-1:0] expRespD;
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      iReq_Valid[p] = rv[p];
      iReq_Write[p] = rw[p];
      iReq_Address[p*AW +: AW] = ra[p];
      iReq_WriteData[p*DW +: DW] = rd[p];
      iReq_ByteEnable[p*NE +: NE] = rbe[p];
    end
  endtask
  task automatic setReq(int p, logic v, logic w, logic [AW-1:0] a, logic [DW-1:0] d, logic [NE-1:0] be);
    rv[p] = v; rw[p] = w; ra[p] = a; rd[p] = d; rbe[p] = be;
  endtask
  task automatic clearReqs();
    for (int p = 0; p < NP; p++) setReq(p, 1'b0, 1'b0, '0, '0, '0);
  endtask
  task automatic resetModel();
    for (int i = 0; i < 1024; i++) refMem[i] = initWord(i);
    for (int b = 0; b < NB; b++) ptr[b] = 0;
    expRespV = '0;
    expRespD = '0;
  endtask
  // Winner = requester with the smallest distance from the bank pointer (round-robin) or the lowest index.
  function automatic int winner(int b);
    int best, bestKey, key;
    best = -1;
    bestKey = NP;
    for (int p = 0; p < NP; p++)
      if (iReset && rv[p] && int'(ra[p][1:0]) == b) begin
`ifdef LM_XBAR_RR_ARB_EN
        key = (p - ptr[b] + NP) % NP;
`else
        key = p;
`endif
        if (key < bestKey) begin
          bestKey = key;
          best = p;
        end
      end
    return best;
  endfunction
  task automatic step();
    int g [NB];
    logic [NP-1:0] gv, es, nV;
    logic [NP*DW-1:0] nD;
    logic [NB*NE-1:0] eWe;
    logic [NB-1:0] eRe;
    logic [NB*MAW-1:0] eA;
    logic [NB*DW-1:0] eWd;
    @(negedge iClk);
    gv = '0; nV = '0; nD = '0; eWe = '0; eRe = '0; eA = '0; eWd = '0;
    for (int b = 0; b < NB; b++) begin
      g[b] = winner(b);
      if (g[b] >= 0) begin
        gv[g[b]] = 1'b1;
        eA[b*MAW +: MAW] = ra[g[b]][9:2];
        if (rw[g[b]]) begin
          eWe[b*NE +: NE] = rbe[g[b]];
          eWd[b*DW +: DW] = rd[g[b]];
        end else begin
          eRe[b] = 1'b1;
          nV[g[b]] = 1'b1;
          nD[g[b]*DW +: DW] = refMem[ra[g[b]][9:0]];
        end
      end
    end
    for (int p = 0; p < NP; p++) es[p] = rv[p] & ~gv[p];
    chk("stall", 128'(oReq_Stall), 128'(es));
    chk("bankWriteEnable", 128'(oBank_WriteEnable), 128'(eWe));
    chk("bankReadEnable", 128'(oBank_ReadEnable), 128'(eRe));
    chk("bankAddress", 128'(oBank_Address), 128'(eA));
    chk("bankWriteData", 128'(oBank_WriteData), 128'(eWd));
    chk("respValid", 128'(oResp_Valid), 128'(expRespV));
    chk("respData", 128'(oResp_ReadData), 128'(expRespD));
    for (int b = 0; b < NB; b++)
      if (g[b] >= 0 && rw[g[b]])
        for (int e = 0; e < NE; e++)
          if (rbe[g[b]][e]) refMem[ra[g[b]][9:0]][e*8 +: 8] = rd[g[b]][e*8 +: 8];
`ifdef LM_XBAR_RR_ARB_EN
    for (int b = 0; b < NB; b++) if (g[b] >= 0) ptr[b] = (g[b] + 1) % NP;
`endif
    expRespV = nV;
    expRespD = nD;
    lastGrant = gv;
    @(posedge iClk);
    #1;
  endtask
  task automatic dropGranted();
    for (int p = 0; p < NP; p++) if (lastGrant[p]) rv[p] = 1'b0;
    drive();
  endtask
  task automatic randReqs();
    for (int p = 0; p < NP; p++)
      if (!rv[p] || lastGrant[p])
        setReq(p, ($urandom % 4) != 0, 1'($urandom), AW'($urandom), $urandom, NE'($urandom));
    drive();
  endtask
  function automatic logic [NP-1:0] validVec();
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) v[p] = rv[p];
    return v;
  endfunction
  initial begin
    resetModel();
    lastGrant = '0;
    clearReqs();
    setReq(1, 1'b1, 1'b0, 16'h0001, '0, '0);
    drive();
    step();
    step();
    iReset = 1'b1;
    clearReqs();
    drive();
    step();
    for (int p = 0; p < NP; p++) setReq(p, 1'b1, 1'b0, AW'(p), '0, '0);
    drive();
    step();
    chk("noConflictStall", 128'(oReq_Stall), 128'(0));
    clearReqs();
    drive();
    step();
    for (int p = 0; p < NP; p++) setReq(p, 1'b1, 1'b0, AW'(4 * (p + 1)), '0, '0);
    drive();
    for (int i = 0; i < 4; i++) begin
      step();
      dropGranted();
    end
    chk("contendDrained", 128'(validVec()), 128'(0));
    step();
    setReq(1, 1'b1, 1'b0, 16'h0002, '0, '0);
    setReq(3, 1'b1, 1'b0, 16'h0006, '0, '0);
    drive();
    for (int i = 0; i < 4; i++) step();
    clearReqs();
    setReq(2, 1'b1, 1'b1, 16'h0015, 32'hDEADBEEF, 4'b0011);
    setReq(0, 1'b1, 1'b0, 16'h0015, '0, '0);
    drive();
    for (int i = 0; i < 2; i++) begin
      step();
      dropGranted();
    end
    setReq(0, 1'b1, 1'b0, 16'h0015, '0, '0);
    drive();
    step();
    clearReqs();
    drive();
    step();
    setReq(0, 1'b1, 1'b1, 16'hFC01, 32'h12345678, 4'hF);
    drive();
    step();
    clearReqs();
    setReq(1, 1'b1, 1'b0, 16'h0001, '0, '0);
    drive();
    step();
    chk("truncRespValid", 128'(oResp_Valid), 128'(4'b0010));
    chk("truncRespData", 128'(oResp_ReadData[DW +: DW]), 128'(32'h12345678));
    clearReqs();
    setReq(0, 1'b1, 1'b0, 16'h0020, '0, '0);
    drive();
    step();
    iReset = 1'b0;
    resetModel();
    for (int p = 0; p < NP; p++) setReq(p, 1'b1, 1'b0, AW'(4 * p), '0, '0);
    drive();
    step();
    iReset = 1'b1;
    step();
    chk("postResetGrant", 128'(lastGrant), 128'(4'b0001));
    for (int i = 0; i < 300; i++) begin
      randReqs();
      step();
    end
    clearReqs();
    drive();
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
